// File: rtl/seg7_display_ctrl.sv
// Avalon-MM seven-segment controller: hex/raw patterns, per-digit blank and blink, registered seg_out.
// Optional macro SEG7_DISPLAY_CTRL_DP_EN adds a decimal point per digit taken from RAW byte bit 7.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS        = 6,
    parameter int SEG_ACTIVE_LOW    = 1,
    parameter int BLINK_HALF_PERIOD = 25000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
`ifdef SEG7_DISPLAY_CTRL_DP_EN
    output logic [NUM_DIGITS*8-1:0] seg_out
`else
    output logic [NUM_DIGITS*7-1:0] seg_out
`endif
);

`ifdef SEG7_DISPLAY_CTRL_DP_EN
    localparam int DIG_W = 8;
`else
    localparam int DIG_W = 7;
`endif
    localparam int SEG_W = NUM_DIGITS * DIG_W;
    localparam int CNT_W = (BLINK_HALF_PERIOD > 2) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_PERIOD - 1);
    localparam logic [SEG_W-1:0] SEG_OFF  = {SEG_W{(SEG_ACTIVE_LOW != 0)}};

    logic                    wr;
    logic                    wr_data;
    logic                    wr_ctrl;
    logic                    wr_raw0;
    logic                    wr_raw1;
    logic                    restart;

    logic [4*NUM_DIGITS-1:0] data_p0;
    logic                    decode_p0;
    logic [NUM_DIGITS-1:0]   blank_p0;
    logic [NUM_DIGITS-1:0]   blink_p0;
    logic [DIG_W-1:0]        raw_p0 [NUM_DIGITS];
    logic [CNT_W-1:0]        cnt_p0;
    logic                    phase_p0;

    logic [SEG_W-1:0]        seg_nxt;
    logic [SEG_W-1:0]        seg_p1;
    logic                    unused_wdata;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    function automatic logic [DIG_W-1:0] to_pins(input logic [DIG_W-1:0] lit);
        return (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    endfunction

    assign wr           = chipselect && !write_n;
    assign wr_data      = wr && (address == 2'd0);
    assign wr_ctrl      = wr && (address == 2'd1);
    assign wr_raw0      = wr && (address == 2'd2);
    assign wr_raw1      = wr && (address == 2'd3);
    assign restart      = wr_ctrl && writedata[31];
    assign unused_wdata = ^writedata;

    // Stage p0: bus-visible register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_p0   <= '0;
            decode_p0 <= 1'b1;
            blank_p0  <= '0;
            blink_p0  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                raw_p0[i] <= '0;
            end
        end else begin
            if (wr_data) begin
                data_p0 <= writedata[4*NUM_DIGITS-1:0];
            end
            if (wr_ctrl) begin
                decode_p0 <= writedata[0];
                blank_p0  <= writedata[8 +: NUM_DIGITS];
                blink_p0  <= writedata[16 +: NUM_DIGITS];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i < 4) ? wr_raw0 : wr_raw1) begin
                    raw_p0[i] <= writedata[8*(i%4) +: DIG_W];
                end
            end
        end
    end

    // A RESTART on the same edge as a wrap wins: phase is forced to 0, not toggled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p0   <= '0;
            phase_p0 <= 1'b0;
        end else if (restart) begin
            cnt_p0   <= '0;
            phase_p0 <= 1'b0;
        end else if (cnt_p0 == CNT_LAST) begin
            cnt_p0   <= '0;
            phase_p0 <= ~phase_p0;
        end else begin
            cnt_p0   <= cnt_p0 + CNT_W'(1);
        end
    end

    // In DP builds bit 7 keeps the RAW byte's DP in both modes; decode only replaces gfedcba.
    always_comb begin
        logic [DIG_W-1:0] pat;
        seg_nxt = '0;
        pat     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pat = raw_p0[i];
            if (decode_p0) begin
                pat[6:0] = hex7(data_p0[4*i +: 4]);
            end
            if (blank_p0[i] || (blink_p0[i] && phase_p0)) begin
                pat = '0;
            end
            seg_nxt[DIG_W*i +: DIG_W] = to_pins(pat);
        end
    end

    // Stage p1: registered pin drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_p1 <= SEG_OFF;
        end else begin
            seg_p1 <= seg_nxt;
        end
    end

    assign seg_out = seg_p1;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[4*NUM_DIGITS-1:0] = data_p0;
            2'd1: begin
                readdata[0]               = decode_p0;
                readdata[8 +: NUM_DIGITS]  = blank_p0;
                readdata[16 +: NUM_DIGITS] = blink_p0;
            end
            2'd2: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i < 4) begin
                        readdata[8*(i%4) +: DIG_W] = raw_p0[i];
                    end
                end
            end
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i >= 4) begin
                        readdata[8*(i%4) +: DIG_W] = raw_p0[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: register table plus blink, restart and reset sequences.
`timescale 1ns/1ps
module tb_seg7_display_ctrl;

`ifdef SEG7_DISPLAY_CTRL_DP_EN
    localparam int DIG_W = 8;
`else
    localparam int DIG_W = 7;
`endif
    localparam int ND    = 6;
    localparam int SEG_W = ND * DIG_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [SEG_W-1:0] seg_out;

    int n_vec = 0;
    int n_bad = 0;

    seg7_display_ctrl #(
        .NUM_DIGITS        (ND),
        .SEG_ACTIVE_LOW    (1),
        .BLINK_HALF_PERIOD (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]          addr;
        logic [31:0]         wdata;
        logic                cs;
        logic                wn;
        logic [1:0]          raddr;
        logic [31:0]         exp_rd;
        logic [ND-1:0][7:0]  exp_dig;   // active-high lit pattern, bit 7 = DP, digit 5 first
    } vec_t;

    vec_t vecs [15];

    function automatic logic [SEG_W-1:0] to_seg(input logic [ND-1:0][7:0] d);
        logic [SEG_W-1:0] s;
        logic [7:0]       b;
        s = '0;
        for (int i = 0; i < ND; i++) begin
            b = ~d[i];
            s[DIG_W*i +: DIG_W] = b[DIG_W-1:0];
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic cs, input logic wn);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = wn;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic check_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, 64'(readdata), 64'(exp));
    endtask

    task automatic check_seg(input string name, input logic [ND-1:0][7:0] d);
        check(name, 64'(seg_out), 64'(to_seg(d)));
    endtask

    initial begin
        logic [7:0] d0;

        vecs[0]  = '{2'd0, 32'h00ABCDEF, 1'b1, 1'b0, 2'd0, 32'h00ABCDEF, {8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71}};
        vecs[1]  = '{2'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 2'd0, 32'h00FFFFFF, {8'h71, 8'h71, 8'h71, 8'h71, 8'h71, 8'h71}};
        vecs[2]  = '{2'd0, 32'h00012345, 1'b1, 1'b0, 2'd0, 32'h00012345, {8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D}};
        vecs[3]  = '{2'd0, 32'h00006789, 1'b1, 1'b0, 2'd0, 32'h00006789, {8'h3F, 8'h3F, 8'h7D, 8'h07, 8'h7F, 8'h6F}};
        vecs[4]  = '{2'd1, 32'h00000000, 1'b1, 1'b0, 2'd1, 32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5]  = '{2'd2, 32'h00000049, 1'b1, 1'b0, 2'd2, 32'h00000049, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h49}};
        vecs[6]  = '{2'd2, 32'h7F7F7F7F, 1'b0, 1'b0, 2'd2, 32'h00000049, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h49}};
        vecs[7]  = '{2'd2, 32'h7F7F7F7F, 1'b1, 1'b1, 2'd2, 32'h00000049, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h49}};
        vecs[8]  = '{2'd2, 32'h7F5B3F06, 1'b1, 1'b0, 2'd2, 32'h7F5B3F06, {8'h00, 8'h00, 8'h7F, 8'h5B, 8'h3F, 8'h06}};
        vecs[9]  = '{2'd3, 32'hFFFF7F77, 1'b1, 1'b0, 2'd3, 32'h00007F77, {8'h7F, 8'h77, 8'h7F, 8'h5B, 8'h3F, 8'h06}};
        vecs[10] = '{2'd1, 32'h00000201, 1'b1, 1'b0, 2'd1, 32'h00000201, {8'h3F, 8'h3F, 8'h7D, 8'h07, 8'h00, 8'h6F}};
        vecs[11] = '{2'd1, 32'h00FFFF01, 1'b1, 1'b0, 2'd1, 32'h003F3F01, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[12] = '{2'd1, 32'h80000001, 1'b1, 1'b0, 2'd1, 32'h00000001, {8'h3F, 8'h3F, 8'h7D, 8'h07, 8'h7F, 8'h6F}};
        vecs[13] = '{2'd1, 32'hFFFFFFFE, 1'b1, 1'b0, 2'd1, 32'h003F3F00, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[14] = '{2'd1, 32'h00000001, 1'b1, 1'b0, 2'd1, 32'h00000001, {8'h3F, 8'h3F, 8'h7D, 8'h07, 8'h7F, 8'h6F}};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state, held and just after release
        repeat (3) @(posedge clk);
        #2;
        check("reset_seg_held", 64'(seg_out), 64'({SEG_W{1'b1}}));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_seg_release", 64'(seg_out), 64'({SEG_W{1'b1}}));
        check_read("reset_ctrl", 2'd1, 32'h00000001);
        check_read("reset_data", 2'd0, 32'h00000000);

        for (int v = 0; v < 15; v++) begin
            bus(vecs[v].addr, vecs[v].wdata, vecs[v].cs, vecs[v].wn);
            @(posedge clk);
            #2;
            check_seg($sformatf("vec%0d_seg", v), vecs[v].exp_dig);
            check_read($sformatf("vec%0d_read", v), vecs[v].raddr, vecs[v].exp_rd);
        end

        // Blink on digit 0 showing '8', restarted by the CTRL write
        bus(2'd0, 32'h00000008, 1'b1, 1'b0);
        bus(2'd1, 32'h80010001, 1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #2;
            d0 = ((((k - 1) / 4) % 2) == 0) ? 8'h7F : 8'h00;
            check_seg($sformatf("blink_k%0d", k), {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, d0});
        end

        // RESTART issued in the off phase: digit 0 returns on the next edge
        bus(2'd1, 32'h80010001, 1'b1, 1'b0);
        #1;
        check_seg("restart_edge", {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h00});
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #2;
            d0 = (k <= 4) ? 8'h7F : 8'h00;
            check_seg($sformatf("restart_k%0d", k), {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, d0});
        end

        // Asynchronous reset during the off phase
        reset_n = 1'b0;
        #1;
        check("midreset_seg", 64'(seg_out), 64'({SEG_W{1'b1}}));
        check_read("midreset_ctrl", 2'd1, 32'h00000001);
        check_read("midreset_data", 2'd0, 32'h00000000);
        check_read("midreset_raw1", 2'd3, 32'h00000000);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("postreset_seg", 64'(seg_out), 64'({SEG_W{1'b1}}));

        // Phase and counter cleared: blink without RESTART starts lit
        bus(2'd0, 32'h00000008, 1'b1, 1'b0);
        bus(2'd1, 32'h00010001, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #2;
            d0 = (k <= 2) ? 8'h7F : 8'h00;
            check_seg($sformatf("postreset_blink_k%0d", k), {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, d0});
        end

        // RAW bit 7: decimal point in DP builds, dropped otherwise
        bus(2'd1, 32'h00000001, 1'b1, 1'b0);
        bus(2'd0, 32'h00000000, 1'b1, 1'b0);
        bus(2'd2, 32'h00000080, 1'b1, 1'b0);
        @(posedge clk);
        #2;
`ifdef SEG7_DISPLAY_CTRL_DP_EN
        check_seg("dp_seg", {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hBF});
        check_read("dp_raw0", 2'd2, 32'h00000080);
`else
        check_seg("nodp_seg", {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F});
        check_read("nodp_raw0", 2'd2, 32'h00000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
